// File: rtl/register_file_entry.sv
// One register of the bank: a DATA_WIDTH-bit flop with synchronous clear and load enable.
module register_file_entry #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] q_reg;

    // Reset wins over a load presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (we) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/register_file.sv
// System-bus register bank: single read/write port with a combinational read,
// plus a parallel export of every register for downstream consumers.
module register_file #(
    parameter  int ENTRIES    = 12,
    parameter  int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  system_reg_en,
    input  logic                  system_reg_we,
    input  logic [ADDR_WIDTH-1:0] system_reg_addr,
    input  logic [DATA_WIDTH-1:0] system_reg_din,
    output logic [DATA_WIDTH-1:0] system_reg_dout,
    output logic [DATA_WIDTH-1:0] reg_values [ENTRIES]
);

    localparam logic [ADDR_WIDTH:0] ENTRIES_W = (ADDR_WIDTH + 1)'(ENTRIES);

    logic               addr_in_range;
    logic               write_req;
    logic [ENTRIES-1:0] entry_we;

    // Non-power-of-two banks leave unused addresses that must neither write nor read.
    assign addr_in_range = ({1'b0, system_reg_addr} < ENTRIES_W);
    assign write_req     = system_reg_en && system_reg_we && addr_in_range;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            assign entry_we[gi] = write_req && (system_reg_addr == ADDR_WIDTH'(gi));

            register_file_entry #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_entry (
                .clk(clk),
                .rst(rst),
                .we (entry_we[gi]),
                .d  (system_reg_din),
                .q  (reg_values[gi])
            );
        end
    endgenerate

    // Read sees the stored value only; no bypass of same-cycle write data.
    always_comb begin
        system_reg_dout = '0;
        if (system_reg_en && addr_in_range) begin
            system_reg_dout = reg_values[system_reg_addr];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table plus hand-written reset sequences.
module tb_register_file;

    localparam int ENTRIES = 12;
    localparam int DW      = 32;
    localparam int AW      = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [DW-1:0] reg_values [ENTRIES];

    logic [DW-1:0] shadow [ENTRIES];
    int n_cmp;
    int n_err;

    typedef struct {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_pre;
        logic [DW-1:0] exp_post;
    } vec_t;

    vec_t vecs [10];

    register_file #(
        .ENTRIES   (ENTRIES),
        .DATA_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .system_reg_en  (en),
        .system_reg_we  (we),
        .system_reg_addr(addr),
        .system_reg_din (din),
        .system_reg_dout(dout),
        .reg_values     (reg_values)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < ENTRIES; i++) begin
            check($sformatf("%s reg_values[%0d]", tag, i), reg_values[i], shadow[i]);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rst  = r;
        en   = e;
        we   = w;
        addr = a;
        din  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0;
        for (int i = 0; i < ENTRIES; i++) shadow[i] = '0;
        tick();
        tick();
        check_all("initial reset");
        $display("txn init_reset: all registers cleared");

        // Test 1: load nonzero data, then a single reset cycle clears everything.
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1'b0, 1'b1, 1'b1, AW'(i), 32'h5500_0000 + i);
            tick();
            shadow[i] = 32'h5500_0000 + i;
        end
        check_all("preload");
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        for (int i = 0; i < ENTRIES; i++) shadow[i] = '0;
        check_all("reset after load");
        drive(1'b0, 1'b1, 1'b0, 4'd0, '0);
        #1 check("reset dout addr0", dout, 32'h0);
        $display("txn reset_after_load: dout=%08h", dout);

        // Directed vectors: pre-edge dout, post-edge dout, full parallel view.
        vecs[0] = '{1'b1, 1'b1, 4'd0,  32'h0000_0BEE, 32'h0000_0000, 32'h0000_0BEE};
        vecs[1] = '{1'b1, 1'b0, 4'd0,  32'h0000_0000, 32'h0000_0BEE, 32'h0000_0BEE};
        vecs[2] = '{1'b1, 1'b1, 4'd0,  32'hFFFF_FFFF, 32'h0000_0BEE, 32'hFFFF_FFFF};
        vecs[3] = '{1'b0, 1'b1, 4'd5,  32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b0, 4'd5,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b1, 4'd13, 32'hCAFE_F00D, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{1'b1, 1'b1, 4'd11, 32'h0000_1111, 32'h0000_0000, 32'h0000_1111};
        vecs[7] = '{1'b1, 1'b1, 4'd12, 32'h7777_7777, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{1'b1, 1'b1, 4'd15, 32'h8888_8888, 32'h0000_0000, 32'h0000_0000};
        vecs[9] = '{1'b1, 1'b0, 4'd0,  32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        for (int v = 0; v < 10; v++) begin
            drive(1'b0, vecs[v].en, vecs[v].we, vecs[v].addr, vecs[v].din);
            #1 check($sformatf("vec%0d dout pre", v), dout, vecs[v].exp_pre);
            tick();
            check($sformatf("vec%0d dout post", v), dout, vecs[v].exp_post);
            if (vecs[v].en && vecs[v].we && vecs[v].addr < ENTRIES) shadow[vecs[v].addr] = vecs[v].din;
            check_all($sformatf("vec%0d", v));
            $display("txn vec%0d: en=%0b we=%0b addr=%0d din=%08h dout=%08h",
                     v, vecs[v].en, vecs[v].we, vecs[v].addr, vecs[v].din, dout);
        end

        // Test 5: fill the whole bank, then random reads including unused addresses.
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1'b0, 1'b1, 1'b1, AW'(i), 32'hA000_0000 + i);
            tick();
            shadow[i] = 32'hA000_0000 + i;
        end
        check_all("fill");
        $display("txn fill: all %0d registers written", ENTRIES);
        for (int k = 0; k < 20; k++) begin
            logic [AW-1:0] ra;
            logic [DW-1:0] exp;
            ra  = AW'($urandom_range(0, 15));
            exp = (ra < ENTRIES) ? (32'hA000_0000 + 32'(ra)) : 32'h0;
            drive(1'b0, 1'b1, 1'b0, ra, 32'hFFFF_0000);
            #1 check($sformatf("rand read addr%0d", ra), dout, exp);
            $display("txn rand_read: addr=%0d dout=%08h", ra, dout);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd3, '0);
        #1 check("en0 read", dout, 32'h0);

        // Test 6: reset and write on the same edge, reset wins.
        drive(1'b1, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
        tick();
        for (int i = 0; i < ENTRIES; i++) shadow[i] = '0;
        check("rst vs write reg3", reg_values[3], 32'h0);
        check_all("rst vs write");
        drive(1'b0, 1'b1, 1'b0, 4'd3, '0);
        #1 check("rst vs write dout", dout, 32'h0);
        $display("txn rst_vs_write: reg3=%08h", reg_values[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
